// File: rtl/button_conditioner.sv
// Pushbutton conditioner: three active-low raw buttons are synchronized,
// debounced with restart-on-bounce counters and presented as active-high
// levels. Execute overrides both loads and also yields a one-cycle press strobe.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic LoadA_raw,
    input  logic LoadB_raw,
    input  logic Execute_raw,
    output logic LoadA,
    output logic LoadB,
    output logic Execute,
    output logic Execute_pulse
);

    localparam int NB = 3;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Button index: 0 = LoadA, 1 = LoadB, 2 = Execute
    localparam int IDX_A = 0;
    localparam int IDX_B = 1;
    localparam int IDX_E = 2;

    logic [NB-1:0]          raw;
    logic [NB-1:0]          synced;
    logic [SYNC_STAGES-1:0] sync [NB];
    logic [CW-1:0]          cnt  [NB];
    logic [NB-1:0]          db;
    logic                   exec_prev;

    assign raw = {Execute_raw, LoadB_raw, LoadA_raw};

    // Last synchronizer stage of each chain is the only copy the debouncer sees.
    always_comb begin
        synced = '0;
        for (int i = 0; i < NB; i++) begin
            synced[i] = sync[i][SYNC_STAGES-1];
        end
    end

    // Synchronizers, debounce counters, debounced state and Execute history.
    // A count only completes after DEBOUNCE_CYCLES consecutive disagreeing
    // cycles; any agreeing cycle clears it, so the counter never passes CNT_LAST.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < NB; i++) begin
                sync[i] <= '1;
                cnt[i]  <= '0;
            end
            db        <= '0;
            exec_prev <= 1'b0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                sync[i] <= {sync[i][SYNC_STAGES-2:0], raw[i]};
                if ((~synced[i]) == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= ~db[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
            exec_prev <= db[IDX_E];
        end
    end

    // Outputs are plain ANDs of registered bits; Execute masks the loads.
    always_comb begin
        Execute       = db[IDX_E];
        LoadA         = db[IDX_A] & ~db[IDX_E];
        LoadB         = db[IDX_B] & ~db[IDX_E];
        Execute_pulse = db[IDX_E] & ~exec_prev;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_button_conditioner;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic LoadA_raw = 1'b1;
    logic LoadB_raw = 1'b1;
    logic Execute_raw = 1'b1;
    logic LoadA, LoadB, Execute, Execute_pulse;

    int errors = 0;
    int checks = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES(2)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .LoadA_raw(LoadA_raw),
        .LoadB_raw(LoadB_raw),
        .Execute_raw(Execute_raw),
        .LoadA(LoadA),
        .LoadB(LoadB),
        .Execute(Execute),
        .Execute_pulse(Execute_pulse)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        Reset_n   = 1'b0;
        LoadA_raw = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            obs = {LoadA, LoadB, Execute, Execute_pulse};
            checks++;
            if (obs !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs cycle=%0d got=%b expected=0000", i, obs);
            end
        end
        Reset_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (LoadA !== (i >= 6)) begin
                errors++;
                $display("FAIL reset_loada_latency edge=%0d got=%b expected=%b", i, LoadA, (i >= 6));
            end
            checks++;
            if (Execute_pulse !== 1'b0 || Execute !== 1'b0 || LoadB !== 1'b0) begin
                errors++;
                $display("FAIL reset_others edge=%0d got=%b%b%b expected=000", i, LoadB, Execute, Execute_pulse);
            end
        end
        LoadA_raw = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (LoadA !== (i < 6)) begin
                errors++;
                $display("FAIL loada_release edge=%0d got=%b expected=%b", i, LoadA, (i < 6));
            end
        end
    endtask

    task automatic test_bounce();
        LoadB_raw = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) LoadB_raw = 1'b1;
            tick();
            checks++;
            if (LoadB !== 1'b0) begin
                errors++;
                $display("FAIL bounce_hold edge=%0d got=%b expected=0", i, LoadB);
            end
        end
        LoadB_raw = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (LoadB !== (i >= 6)) begin
                errors++;
                $display("FAIL bounce_settle edge=%0d got=%b expected=%b", i, LoadB, (i >= 6));
            end
        end
        LoadB_raw = 1'b1;
        repeat (8) tick();
        checks++;
        if (LoadB !== 1'b0) begin
            errors++;
            $display("FAIL bounce_release got=%b expected=0", LoadB);
        end
    endtask

    task automatic test_execute();
        Execute_raw = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if (Execute !== (i >= 6) || Execute_pulse !== (i == 6)) begin
                errors++;
                $display("FAIL exec_press edge=%0d got=%b/%b expected=%b/%b",
                         i, Execute, Execute_pulse, (i >= 6), (i == 6));
            end
        end
        Execute_raw = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (Execute !== (i < 6) || Execute_pulse !== 1'b0) begin
                errors++;
                $display("FAIL exec_release edge=%0d got=%b/%b expected=%b/0",
                         i, Execute, Execute_pulse, (i < 6));
            end
        end
    endtask

    task automatic test_priority();
        LoadA_raw   = 1'b0;
        Execute_raw = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (LoadA !== 1'b0 || Execute !== (i >= 6)) begin
                errors++;
                $display("FAIL prio_hold edge=%0d got=%b/%b expected=0/%b", i, LoadA, Execute, (i >= 6));
            end
        end
        Execute_raw = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (Execute !== (i < 6) || LoadA !== (i >= 6)) begin
                errors++;
                $display("FAIL prio_handoff edge=%0d got=%b/%b expected=%b/%b",
                         i, Execute, LoadA, (i < 6), (i >= 6));
            end
        end
        LoadA_raw = 1'b1;
        repeat (8) tick();
        checks++;
        if (LoadA !== 1'b0) begin
            errors++;
            $display("FAIL prio_release got=%b expected=0", LoadA);
        end
    endtask

    task automatic test_reset_midcount();
        LoadA_raw = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (LoadA !== 1'b0) begin
                errors++;
                $display("FAIL abort_precount edge=%0d got=%b expected=0", i, LoadA);
            end
        end
        Reset_n = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++;
            if (LoadA !== 1'b0) begin
                errors++;
                $display("FAIL abort_in_reset edge=%0d got=%b expected=0", i, LoadA);
            end
        end
        Reset_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (LoadA !== (i >= 6)) begin
                errors++;
                $display("FAIL abort_recount edge=%0d got=%b expected=%b", i, LoadA, (i >= 6));
            end
        end
        LoadA_raw = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_random_chatter();
        int run [3];
        logic [2:0] lvl;
        logic [3:0] obs;
        lvl = 3'b111;
        for (int b = 0; b < 3; b++) run[b] = $urandom_range(3, 1);
        for (int c = 1; c <= 1000; c++) begin
            for (int b = 0; b < 3; b++) begin
                run[b]--;
                if (run[b] == 0) begin
                    lvl[b] = ~lvl[b];
                    run[b] = $urandom_range(3, 1);
                end
            end
            {Execute_raw, LoadB_raw, LoadA_raw} = lvl;
            tick();
            obs = {LoadA, LoadB, Execute, Execute_pulse};
            checks++;
            if (obs !== 4'b0000) begin
                errors++;
                $display("FAIL chatter_outputs cycle=%0d got=%b expected=0000", c, obs);
            end
            for (int b = 0; b < 3; b++) begin
                checks++;
                if (dut.cnt[b] > 3) begin
                    errors++;
                    $display("FAIL chatter_counter cycle=%0d button=%0d got=%0d expected<=3", c, b, dut.cnt[b]);
                end
            end
        end
        {Execute_raw, LoadB_raw, LoadA_raw} = 3'b111;
        repeat (8) tick();
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_execute();
        test_priority();
        test_reset_midcount();
        test_random_chatter();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, number of consecutive stable synchronized cycles needed before a debounced output changes (legal range >= 2).
REQ-002 Parameter SYNC_STAGES, default 2, flip-flop depth of each input synchronizer (legal range >= 2).
REQ-003 Clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of Clk.
REQ-005 LoadA_raw, LoadB_raw, Execute_raw  input  1 each  asynchronous pushbutton levels, active-low (0 = pressed).
REQ-006 LoadA, LoadB, Execute  output  1 each  debounced, active-high button levels that drive the multiplier control FSM.
REQ-007 Execute_pulse  output  1  single-cycle strobe on each debounced Execute press.

Function
REQ-008 Each raw input SHALL pass through its own SYNC_STAGES-deep flip-flop chain; only the last stage output ("synced") feeds further logic.
REQ-009 Each button SHALL have an independent counter of width $clog2(DEBOUNCE_CYCLES+1) and a debounced state bit db (1 = pressed).
REQ-010 In any cycle where the inverted synced value equals db, that button's counter SHALL load 0.
REQ-011 In any cycle where the inverted synced value differs from db, the counter SHALL increment; when it reaches DEBOUNCE_CYCLES-1, db SHALL toggle on that edge and the counter SHALL load 0.
REQ-012 A single cycle of agreement during a count (bounce) SHALL restart the count from 0; no partial credit is kept.
REQ-013 Latency: a clean raw edge SHALL appear on db exactly SYNC_STAGES + DEBOUNCE_CYCLES rising edges after the first edge that samples the new raw level.
REQ-014 Execute SHALL equal db_Execute.
REQ-015 LoadA SHALL equal db_LoadA AND NOT db_Execute; LoadB SHALL equal db_LoadB AND NOT db_Execute (Execute has priority; loads suppressed while Execute is held).
REQ-016 If db_Execute and db_LoadA/db_LoadB become 1 on the same edge, LoadA/LoadB SHALL be 0 on that cycle.
REQ-017 When db_Execute falls while db_LoadA/db_LoadB is 1, LoadA/LoadB SHALL be 1 from the cycle db_Execute is 0.
REQ-018 Execute_pulse SHALL be 1 for exactly the one cycle in which db_Execute is 1 and its registered previous value is 0; 0 otherwise, including during holds and on release.
REQ-019 All outputs SHALL be registered or a pure AND of registered bits; no raw input reaches an output combinationally.
REQ-020 Counter SHALL never exceed DEBOUNCE_CYCLES-1; no wrap-around is permitted.

Reset
REQ-021 While Reset_n = 0 at a rising edge, all synchronizer stages SHALL load 1 (released), all counters 0, all db bits and the Execute history bit 0.
REQ-022 During and on the first cycle after reset, LoadA, LoadB, Execute and Execute_pulse SHALL be 0.
REQ-023 Reset asserted mid-count SHALL discard the count; after release a held button requires the full REQ-013 latency again.
REQ-024 Reset SHALL override every other update on the same edge.

Verification (DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2)
REQ-025 Reset_n = 0 for 3 edges with LoadA_raw = 0 held -> all outputs 0 during reset; after release LoadA rises exactly 6 edges after first post-reset sample, Execute_pulse stays 0.
REQ-026 LoadB_raw: 0 for 3 cycles, 1 for 1 cycle, then 0 stable -> LoadB stays 0 through the bounce, rises 6 edges after the final falling edge is sampled.
REQ-027 Execute_raw pressed and held 20 cycles then released -> Execute 1 after 6 edges, Execute_pulse high exactly one cycle aligned with Execute rise, Execute 0 six edges after release sampled, no pulse on release.
REQ-028 LoadA_raw and Execute_raw pressed same cycle, LoadA_raw held after Execute_raw released -> LoadA 0 while Execute 1, LoadA 1 on the first cycle Execute is 0.
REQ-029 LoadA_raw pressed, Reset_n pulsed low after 4 cycles -> LoadA never asserts during the aborted count; rises 6 edges after reset release.
REQ-030 Random raw toggling with periods < 4 cycles for 1000 cycles -> no output ever changes; counter never exceeds 3.
